// File: rtl/ase_pkg.sv
// Shared CCI-P MMIO types, CSR map and length encodings for the ASE MMIO responder.
package ase_pkg;

   localparam int unsigned CCIP_DATA_WIDTH        = 512;
   localparam int unsigned CCIP_MMIO_RDDATA_WIDTH = 64;

   localparam int unsigned CSR_DFH      = 0;
   localparam int unsigned CSR_AFUID_L  = 1;
   localparam int unsigned CSR_AFUID_H  = 2;
   localparam int unsigned CSR_STATUS   = 3;
   localparam int unsigned CSR_WRCOUNT  = 4;
   localparam int unsigned CSR_FIRST_RW = 5;

   localparam logic [1:0] MMIO_LEN_4B  = 2'b00;
   localparam logic [1:0] MMIO_LEN_8B  = 2'b01;
   localparam logic [1:0] MMIO_LEN_64B = 2'b10;

   typedef logic [27:0] RxHdr_t;

   typedef struct packed {
      logic [15:0] index;
      logic [1:0]  len;
      logic        rsvd;
      logic [8:0]  tid;
   } CfgHdr_t;

   typedef struct packed {
      logic [8:0] tid;
   } MMIOHdr_t;

   typedef struct packed {
      logic        valid;
      logic [8:0]  tid;
      logic [63:0] data;
   } rspEntry_t;

endpackage

// File: rtl/ccip_mmio_responder_if.sv
// C0 Rx MMIO request / C2 Tx MMIO response bundle between the CCI-P bridge and the responder.
interface ccip_mmio_responder_if;
   import ase_pkg::*;

   RxHdr_t                              C0RxHdr;
   logic                                C0RxMMIOWrValid;
   logic                                C0RxMMIORdValid;
   logic [CCIP_DATA_WIDTH-1:0]          C0RxData;
   MMIOHdr_t                            C2TxHdr;
   logic                                C2TxMMIORdValid;
   logic [CCIP_MMIO_RDDATA_WIDTH-1:0]   C2TxData;

   modport master (
      output C0RxHdr, C0RxMMIOWrValid, C0RxMMIORdValid, C0RxData,
      input  C2TxHdr, C2TxMMIORdValid, C2TxData
   );

   modport slave (
      input  C0RxHdr, C0RxMMIOWrValid, C0RxMMIORdValid, C0RxData,
      output C2TxHdr, C2TxMMIORdValid, C2TxData
   );

endinterface

// File: rtl/ccip_mmio_rsp_pipe.sv
// Fixed-latency delay line for MMIO read responses; clr drops everything in flight.
module ccip_mmio_rsp_pipe
   import ase_pkg::*;
#(
   parameter int unsigned RSP_LATENCY = 2
) (
   input  logic      clk,
   input  logic      clr,
   input  rspEntry_t inEntry,
   output rspEntry_t outEntry
);

   rspEntry_t stageQ [RSP_LATENCY];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int unsigned i = 0; i < RSP_LATENCY; i++) stageQ[i] <= '0;
      end else begin
         stageQ[0] <= inEntry;
         for (int unsigned i = 1; i < RSP_LATENCY; i++) stageQ[i] <= stageQ[i-1];
      end
   end

   assign outEntry = stageQ[RSP_LATENCY-1];

endmodule

// File: rtl/ccip_mmio_responder.sv
// CCI-P MMIO endpoint: CSR bank, write counter and fixed-latency read responses on C2.
// Define MMIO_RSP_ERRCHK_EN for the sticky mmio_err protocol checker and strict 8B alignment.
module ccip_mmio_responder
   import ase_pkg::*;
#(
   parameter int unsigned  NUM_CSR     = 8,
   parameter logic [15:0]  CSR_BASE    = 16'h0000,
   parameter int unsigned  RSP_LATENCY = 2,
   parameter logic [63:0]  DFH_VALUE   = 64'h0,
   parameter logic [127:0] AFU_ID      = 128'h0
) (
   input  logic                    clk,
   input  logic                    SoftReset,
   ccip_mmio_responder_if.slave    mmio,
   input  logic [63:0]             afu_status,
   output logic [NUM_CSR*64-1:0]   csr_scratch,
   output logic                    mmio_err
);

   localparam int unsigned SelW = $clog2(NUM_CSR);

   CfgHdr_t        hdr;
   logic [16:0]    relIdx;
   logic           inRange;
   logic [SelW-1:0] csrSel;
   logic           dwSel, len4, len8, lenOk, misalign;
   logic           wrValid, rdValid, wrHit;
   logic [63:0]    wrData, csrVal, rdData;
   logic [63:0]    rwQ [NUM_CSR];
   logic [31:0]    wrCountQ;
   logic [63:0]    statusQ;
   rspEntry_t      rspIn, rspOut;

   assign hdr     = CfgHdr_t'(mmio.C0RxHdr);
   assign relIdx  = {1'b0, hdr.index} - {1'b0, CSR_BASE};
   assign inRange = !relIdx[16] && (relIdx < 17'(2 * NUM_CSR));
   assign csrSel  = relIdx[SelW:1];
   assign dwSel   = relIdx[0];
   assign len4    = (hdr.len == MMIO_LEN_4B);
   assign len8    = (hdr.len == MMIO_LEN_8B);
   assign lenOk   = len4 || len8;
   assign wrValid = mmio.C0RxMMIOWrValid;
   assign rdValid = mmio.C0RxMMIORdValid;
   assign wrData  = mmio.C0RxData[63:0];

`ifdef MMIO_RSP_ERRCHK_EN
   assign misalign = len8 && hdr.index[0];
`else
   assign misalign = 1'b0;
`endif

   assign wrHit = wrValid && inRange && lenOk && !misalign &&
                  (csrSel >= SelW'(CSR_FIRST_RW));

   always_comb begin
      csrVal = '0;
      if (csrSel == SelW'(CSR_DFH))          csrVal = DFH_VALUE;
      else if (csrSel == SelW'(CSR_AFUID_L)) csrVal = AFU_ID[63:0];
      else if (csrSel == SelW'(CSR_AFUID_H)) csrVal = AFU_ID[127:64];
      else if (csrSel == SelW'(CSR_STATUS))  csrVal = afu_status;
      else if (csrSel == SelW'(CSR_WRCOUNT)) csrVal = {32'b0, wrCountQ};
      else begin
         for (int unsigned k = CSR_FIRST_RW; k < NUM_CSR; k++) begin
            if (csrSel == SelW'(k)) csrVal = rwQ[k];
         end
      end
   end

   // Bad requests still answer (with zero) so software never waits forever.
   always_comb begin
      rdData = '0;
      if (inRange && lenOk && !misalign) begin
         rdData = len8 ? csrVal : {32'b0, (dwSel ? csrVal[63:32] : csrVal[31:0])};
      end
   end

   always_comb begin
      rspIn.valid = rdValid && !wrValid;
      rspIn.tid   = hdr.tid;
      rspIn.data  = rspIn.valid ? rdData : 64'h0;
   end

   always_ff @(posedge clk) begin
      if (SoftReset) begin
         for (int unsigned k = 0; k < NUM_CSR; k++) rwQ[k] <= '0;
         wrCountQ <= '0;
         statusQ  <= '0;
      end else begin
         statusQ <= afu_status;
         if (wrHit) begin
            wrCountQ <= wrCountQ + 32'd1;
            for (int unsigned k = CSR_FIRST_RW; k < NUM_CSR; k++) begin
               if (csrSel == SelW'(k)) begin
                  if (len8)       rwQ[k]        <= wrData;
                  else if (dwSel) rwQ[k][63:32] <= wrData[31:0];
                  else            rwQ[k][31:0]  <= wrData[31:0];
               end
            end
         end
      end
   end

   ccip_mmio_rsp_pipe #(
      .RSP_LATENCY(RSP_LATENCY)
   ) u_pipe (
      .clk     (clk),
      .clr     (SoftReset),
      .inEntry (rspIn),
      .outEntry(rspOut)
   );

   assign mmio.C2TxMMIORdValid = rspOut.valid;
   assign mmio.C2TxHdr.tid     = rspOut.tid;
   assign mmio.C2TxData        = rspOut.data;

   always_comb begin
      csr_scratch = '0;
      csr_scratch[CSR_DFH*64     +: 64] = DFH_VALUE;
      csr_scratch[CSR_AFUID_L*64 +: 64] = AFU_ID[63:0];
      csr_scratch[CSR_AFUID_H*64 +: 64] = AFU_ID[127:64];
      csr_scratch[CSR_STATUS*64  +: 64] = statusQ;
      csr_scratch[CSR_WRCOUNT*64 +: 64] = {32'b0, wrCountQ};
      for (int unsigned k = CSR_FIRST_RW; k < NUM_CSR; k++) csr_scratch[k*64 +: 64] = rwQ[k];
   end

`ifdef MMIO_RSP_ERRCHK_EN
   logic errQ, errEvent;

   assign errEvent = ((wrValid || rdValid) && (!lenOk || misalign || !inRange)) ||
                     (wrValid && inRange && (csrSel < SelW'(CSR_FIRST_RW))) ||
                     (wrValid && rdValid);

   always_ff @(posedge clk) begin
      if (SoftReset)     errQ <= 1'b0;
      else if (errEvent) errQ <= 1'b1;
   end

   assign mmio_err = errQ;
`else
   assign mmio_err = 1'b0;
`endif

   logic unusedBits;
   assign unusedBits = ^{mmio.C0RxData[CCIP_DATA_WIDTH-1:64], hdr.rsvd};

endmodule

// File: doc/ccip_mmio_responder.md
Name: ccip_mmio_responder

Overview:
- AFU-side responder for CCI-P MMIO traffic.
- Decodes SW MMIO write and read requests arriving on C0 Rx and holds a small CSR bank.
- Returns MMIO read responses on the C2 Tx channel with the request tid echoed, after a fixed latency.
- Sits between the ASE CCI-P bridge and AFU user logic; ASE and sample AFUs use it as the standard MMIO endpoint.

Parameters:
- NUM_CSR, 8, number of 64-bit CSRs (min 6, max 64).
- CSR_BASE, 16'h0000, DWORD index of CSR 0.
- RSP_LATENCY, 2, cycles from read request to C2TxMMIORdValid (1..16).
- DFH_VALUE, 64'h0, read-only value of CSR 0.
- AFU_ID, 128'h0, read-only value of CSR 1 (low half) and CSR 2 (high half).

Ports:
- clk  in  1  clock.
- SoftReset  in  1  synchronous, active-high reset.
- C0RxHdr  in  RxHdr_t  header; cast to CfgHdr_t to get index[15:0], len[1:0], tid[8:0].
- C0RxMMIOWrValid  in  1  MMIO write request.
- C0RxMMIORdValid  in  1  MMIO read request.
- C0RxData  in  CCIP_DATA_WIDTH  write data; only [63:0] used.
- C2TxHdr  out  MMIOHdr_t  response header (tid).
- C2TxMMIORdValid  out  1  read response strobe, one cycle.
- C2TxData  out  CCIP_MMIO_RDDATA_WIDTH(64)  read data.
- afu_status  in  64  value returned by CSR 3.
- csr_scratch  out  NUM_CSR*64  flat view of all CSRs, for AFU logic.
- mmio_err  out  1  sticky protocol error; optional feature only.

Behaviour:
- Address map: CSR k occupies DWORD indices CSR_BASE+2k (low DW) and CSR_BASE+2k+1 (high DW).
  - k=0: DFH, read-only.
  - k=1, k=2: AFU_ID, read-only.
  - k=3: afu_status, read-only.
  - k=4: WRCOUNT, read-only; 32-bit count of accepted writes, zero-extended to 64 bits, wraps at 2^32-1 to 0.
  - k>=5: read/write, reset value 0.
- Length codes: len 2'b00 = 4B, 2'b01 = 8B, 2'b10 and 2'b11 unsupported.
- Writes:
  - Take effect on the clock edge of the valid cycle and are visible to a read issued the next cycle.
  - 8B write: index[0] must be 0; full CSR written.
  - 4B write: updates the DWORD selected by index[0] from C0RxData[31:0].
  - Writes to read-only CSRs, out-of-range indices, or unsupported len are dropped and not counted in WRCOUNT.
  - Every write that updates a CSR increments WRCOUNT.
- Reads:
  - Data is snapshotted in the request cycle N; C2TxMMIORdValid pulses at N+RSP_LATENCY with the same tid.
  - A write at N+1 never alters the response to the read at N.
  - 8B read returns the full CSR.
  - 4B read returns the selected DWORD in [31:0], with [63:32]=0.
  - Out-of-range index or unsupported len still responds, with data 0; SW must never hang.
- Pipeline: delay line of depth RSP_LATENCY carrying {valid, tid, data}.
  - Accepts one read per cycle; no backpressure exists on C2.
  - Back-to-back reads produce back-to-back responses in request order.
- Simultaneous Wr and Rd valid (illegal on CCI-P): the write is performed, the read is dropped, and mmio_err is set if the optional feature is present.
- Reset values: C2TxMMIORdValid=0, C2TxHdr=0, C2TxData=0, RW CSRs=0, WRCOUNT=0, mmio_err=0.
- SoftReset mid-operation: all in-flight responses are discarded and no response is emitted for them; requests presented during reset are ignored.
- No state machine beyond the delay line and the counters; all outputs are registered.

Optional Feature:
- Macro: MMIO_RSP_ERRCHK_EN.
- With the macro defined: mmio_err is set and held until SoftReset on any of:
  - unsupported len;
  - 8B access with index[0]=1;
  - out-of-range index;
  - write to a read-only CSR;
  - simultaneous Wr and Rd valid.
- Without the macro: mmio_err is tied 0, and an 8B access with index[0]=1 is treated as aligned (index[0] ignored). All other behaviour is identical.

Decomposition:
- ase_pkg holds:
  - CSR index localparams: CSR_DFH=0, CSR_AFUID_L=1, CSR_AFUID_H=2, CSR_STATUS=3, CSR_WRCOUNT=4, CSR_FIRST_RW=5;
  - MMIO len encodings MMIO_LEN_4B, MMIO_LEN_8B, MMIO_LEN_64B;
  - reuse of CfgHdr_t and MMIOHdr_t.
- Sub-module ccip_mmio_rsp_pipe: parameterised RSP_LATENCY delay line with synchronous clear.

Test Plan:
- 8B write 64'hDEADBEEF_CAFEF00D to CSR 5 (index 10), then 8B read tid=9'h03 -> response 2 cycles later, tid 03, data DEADBEEF_CAFEF00D; WRCOUNT reads 1.
- 4B write 32'h12345678 to index 13 (CSR 6 high), then 8B read CSR 6 -> 64'h12345678_00000000; 4B read index 13 -> 64'h00000000_12345678.
- Write 64'hFFFF to CSR 0, then read CSR 0 -> DFH_VALUE unchanged; WRCOUNT unchanged; mmio_err=1 with the feature, 0 without.
- Reads tid 1,2,3 on consecutive cycles to index 6 (afu_status=64'hA5) and index 200 (out of range) -> three consecutive responses in order, data A5, A5, 0.
- Read issued, SoftReset asserted the next cycle for 1 cycle -> no C2TxMMIORdValid; CSR 5 reads 0 afterwards.
- Read CSR 5 at cycle N, 8B write 64'h1 to CSR 5 at N+1 -> response at N+2 carries the old value.
